// File: rtl/goertzel_sched_if.sv
// rtl/goertzel_sched_if.sv - CORDIC request and Goertzel bank signal bundle for goertzel_sched
interface goertzel_sched_if #(
  parameter int NF = 11,
  parameter int FW = 16,
  parameter int CW = 16
);
  logic          cordic_req;
  logic [FW-1:0] cordic_freq;
  logic          cordic_ack;
  logic [CW-1:0] cordic_cos;
  logic [CW-1:0] cordic_sin;
  logic [NF-1:0] coef_we;
  logic [CW-1:0] coef_cos;
  logic [CW-1:0] coef_sin;
  logic          gz_clear;
  logic          gz_en;
  logic [NF-1:0] gz_done;

  modport master (
    output cordic_req, cordic_freq, coef_we, coef_cos, coef_sin, gz_clear, gz_en,
    input  cordic_ack, cordic_cos, cordic_sin, gz_done
  );

  modport slave (
    input  cordic_req, cordic_freq, coef_we, coef_cos, coef_sin, gz_clear, gz_en,
    output cordic_ack, cordic_cos, cordic_sin, gz_done
  );
endinterface

// File: rtl/goertzel_sched.sv
// rtl/goertzel_sched.sv - run sequencer: per-bin CORDIC coefficient load, sample gating, result flush
module goertzel_sched #(
  parameter int NF       = 11,
  parameter int NS       = 100000,
  parameter int FW       = 16,
  parameter int CW       = 16,
  parameter int FLUSH_TO = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NF*FW-1:0]      freq,
  input  logic                  smp_valid,
  output logic [$clog2(NF)-1:0] slot,
  output logic                  busy,
  output logic                  coef_ready,
  output logic                  done,
  output logic                  timeout,
  output logic                  ign_start,
  goertzel_sched_if.master      bus
);
  localparam int SW = $clog2(NF);
  localparam int NW = $clog2(NS + 1);
  localparam int TW = $clog2(FLUSH_TO + 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NF - 1);
  localparam logic [NW-1:0] LAST_SMP  = NW'(NS - 1);
  localparam logic [TW-1:0] LAST_TO   = TW'(FLUSH_TO - 1);
  localparam logic [NF-1:0] WE_ONE    = NF'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_REQ, S_LOAD, S_RUN, S_FLUSH, S_DONE
  } state_t;

  state_t        state;
  logic [NW-1:0] smp_cnt;
  logic [TW-1:0] flush_cnt;
  logic          cordic_req_q;
  logic          gz_clear_q;
  logic [NF-1:0] coef_we_q;
  logic [CW-1:0] cos_q;
  logic [CW-1:0] sin_q;
  logic          accept;

  // A sample is gated to the banks only in RUN, and never in a cycle that is being cancelled.
  assign accept          = (state == S_RUN) && smp_valid && rstn && !abort;
  assign bus.gz_en       = accept;
  assign bus.cordic_req  = cordic_req_q;
  assign bus.cordic_freq = cordic_req_q ? freq[int'(slot)*FW +: FW] : '0;
  assign bus.gz_clear    = gz_clear_q;
  assign bus.coef_we     = coef_we_q;
  assign bus.coef_cos    = cos_q;
  assign bus.coef_sin    = sin_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      slot         <= '0;
      smp_cnt      <= '0;
      flush_cnt    <= '0;
      cordic_req_q <= 1'b0;
      gz_clear_q   <= 1'b0;
      coef_we_q    <= '0;
      cos_q        <= '0;
      sin_q        <= '0;
      busy         <= 1'b0;
      coef_ready   <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      ign_start    <= 1'b0;
    end else if (abort) begin
      state        <= S_IDLE;
      cordic_req_q <= 1'b0;
      gz_clear_q   <= 1'b0;
      coef_we_q    <= '0;
      busy         <= 1'b0;
      coef_ready   <= 1'b0;
      done         <= 1'b0;
    end else begin
      gz_clear_q <= 1'b0;
      coef_we_q  <= '0;
      if (start && busy) ign_start <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_CLR;
            gz_clear_q <= 1'b1;
            slot       <= '0;
            smp_cnt    <= '0;
            flush_cnt  <= '0;
            busy       <= 1'b1;
            coef_ready <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            ign_start  <= 1'b0;
          end
        end
        S_CLR: begin
          state        <= S_REQ;
          cordic_req_q <= 1'b1;
        end
        S_REQ: begin
          if (bus.cordic_ack) begin
            cos_q        <= bus.cordic_cos;
            sin_q        <= bus.cordic_sin;
            coef_we_q    <= WE_ONE << slot;
            cordic_req_q <= 1'b0;
            state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (slot == LAST_SLOT) begin
            coef_ready <= 1'b1;
            state      <= S_RUN;
          end else begin
            slot         <= slot + 1'b1;
            cordic_req_q <= 1'b1;
            state        <= S_REQ;
          end
        end
        S_RUN: begin
          if (accept) begin
            smp_cnt <= smp_cnt + 1'b1;
            if (smp_cnt == LAST_SMP) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // A full set of results wins even on the last cycle of the wait window.
          if (&bus.gz_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else if (flush_cnt == LAST_TO) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
